multicycle_control_unit: RTL
============================

Name: multicycle_control_unit

Overview:
- Parametrised, stall-aware successor to the MUSA multi-cycle control unit.
- Sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK per instruction and drives datapath strobes.
- Adds multi-cycle MUL/DIV wait counting, a HALT state with resume, stack overflow/underflow trapping on CALL/RET, and an illegal-opcode trap.
- Sits in the ID stage between the instruction register and the datapath muxes, register file, data memory and return stack.

Parameters:
- OPW, 6: opcode width; must be >= 6; opcodes are zero-extended to OPW.
- ALUOP_W, 3: aluOp width; must be >= 3; upper bits are 0.
- MULDIV_CYCLES, 4: EXECUTE cycles for MUL/DIV; must be >= 1.
- HALT_OP, 6'b111111 zero-extended to OPW: HALT opcode.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  OPW  current instruction opcode.
- flag  in  1  ALU compare flag, used by BRFL and JR.
- stall  in  1  freeze sequencing; all strobes forced to 0.
- resume  in  1  leave HALTED.
- stack_full  in  1  return stack full.
- stack_empty  in  1  return stack empty.
- memRead, memWrite, memToReg, regWrite, regDst, PCWrite, push, pop  out  1 each  datapath controls.
- pcSrc  out  2  00 = PC+1, 01 = branch target, 10 = jump target, 11 = stack top.
- aluSrc  out  2  00 = reg, 01 = sign-extended imm, 10 = zero-extended imm, 11 = PC.
- aluOp  out  ALUOP_W  000 add, 001 sub, 010 and, 011 or, 100 funct, 101 mul, 110 div.
- stage  out  3  current state encoding.
- halted  out  1  high in HALTED.
- illegal  out  1  high in TRAP.

Behaviour:
- Clock/reset: one clock, clk. Reset is asynchronous, active-high, on port rst. While rst=1: state=FETCH, stage=000, wait counter=0, every output 0.
- Opcode capture: opcode is latched into an internal register on the FETCH->DECODE edge. All outputs are a function of state and the latched opcode only; they never follow the live opcode input.
- Opcodes: R-type/CMP 000000, MUL 011100, DIV 000101, ADDI 001000, SUBI 001001, ANDI 001100, ORI 001101, LW 100011, SW 101011, JR 010001, JPC 000010, BRFL 000100, CALL 000011, RET 000001, HALT = HALT_OP. Anything else is illegal.
- Stage encodings: FETCH 000, DECODE 001, EXECUTE 010, MEM 011, WRITEBACK 100, HALTED 101, TRAP 110. Outputs not listed for a state are 0.
- FETCH: PCWrite=1, pcSrc=00. Next state DECODE.
- DECODE: no strobes. HALT -> HALTED; illegal -> TRAP; otherwise -> EXECUTE. On entry to EXECUTE, the wait counter loads MULDIV_CYCLES-1 for MUL/DIV, else 0.
- EXECUTE, ALU instructions: aluOp = 100 (R-type), 101 (MUL), 110 (DIV), 000 (ADDI), 001 (SUBI), 010 (ANDI), 011 (ORI). aluSrc = 01 for ADDI/SUBI, 10 for ANDI/ORI, else 00. If counter != 0: decrement and stay in EXECUTE. Otherwise -> WRITEBACK. MUL/DIV therefore spend exactly MULDIV_CYCLES cycles in EXECUTE.
- EXECUTE, LW/SW: aluOp=000, aluSrc=01. Next state MEM.
- EXECUTE, JPC: PCWrite=1, pcSrc=10. Next state FETCH.
- EXECUTE, CALL: push=1, PCWrite=1, pcSrc=10. Next state FETCH. If stack_full=1: no strobes, next state TRAP.
- EXECUTE, RET: pop=1, PCWrite=1, pcSrc=11. Next state FETCH. If stack_empty=1: no strobes, next state TRAP.
- EXECUTE, BRFL/JR: aluOp=001, pcSrc=01. PCWrite = flag for BRFL, ~flag for JR. Next state FETCH.
- MEM: LW drives memRead=1, then -> WRITEBACK. SW drives memWrite=1, then -> FETCH.
- WRITEBACK: regWrite=1; memToReg=1 only for LW; regDst=1 for R-type/MUL/DIV. Next state FETCH.
- HALTED: halted=1. resume=1 -> FETCH; otherwise hold.
- TRAP: illegal=1. Sticky until rst; resume has no effect.
- stall=1 in FETCH..WRITEBACK: state and counter hold. memRead, memWrite, regWrite, PCWrite, push and pop are forced to 0. Mux selects (pcSrc, aluSrc, aluOp, regDst, memToReg) keep their values. stall is ignored in HALTED and TRAP.
- Stall/event precedence: a CALL/RET stack check is evaluated only in a non-stalled EXECUTE cycle.
- Reset mid-instruction: rst asserted in any state aborts immediately; no strobe survives the reset edge.

Decomposition:
- Package musa_ctrl_pkg holds:
  - opcode localparams;
  - aluOp, aluSrc and pcSrc codes;
  - stage encodings.
- One natural sub-module: ctrl_decode. It is purely combinational: it maps the latched opcode to an instruction-class one-hot (alu, muldiv, mem_ld, mem_st, jump, call, ret, branch, halt, illegal). The FSM and wait counter stay in the top module.

Test Plan:
- Reset/ADDI: hold rst 3 cycles, then opcode=001000. Required: stage 000,001,010,100,000. WRITEBACK cycle has regWrite=1, regDst=0. EXECUTE cycle has aluSrc=01, aluOp=000. All outputs 0 during reset.
- LW then SW: LW required MEM with memRead=1, then WRITEBACK with memToReg=1 (5 cycles total). SW required MEM with memWrite=1, then FETCH (4 cycles), regWrite never 1.
- MUL with MULDIV_CYCLES=4: required 4 consecutive EXECUTE cycles with aluOp=101. Rerun with stall=1 for 2 cycles mid-EXECUTE: required 6 EXECUTE cycles, strobes 0 during the stall.
- Control flow: BRFL with flag=1 -> PCWrite=1, pcSrc=01. BRFL with flag=0 -> PCWrite=0. JR with flag=0 -> PCWrite=1. CALL -> push=1, pcSrc=10. RET -> pop=1, pcSrc=11.
- Traps: CALL with stack_full=1 -> stage 110, illegal=1, push=0. Opcode 111000 -> TRAP after DECODE. resume=1 -> stays in TRAP; rst -> FETCH.
- HALT: opcode 111111 -> stage 101, halted=1, held 10 cycles. resume pulse -> FETCH on the next edge. rst asserted during EXECUTE -> stage=000 asynchronously.

Source files
------------

// File: rtl/musa_ctrl_pkg.sv
// Shared constants for the multi-cycle control unit: opcodes, datapath
// select codes, stage encodings and the decoded instruction-class payload.
package musa_ctrl_pkg;

  // Base 6-bit opcodes; zero-extended to the configured opcode width at use.
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_MUL   = 6'b011100;
  localparam logic [5:0] OP_DIV   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SUBI  = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_JR    = 6'b010001;
  localparam logic [5:0] OP_JPC   = 6'b000010;
  localparam logic [5:0] OP_BRFL  = 6'b000100;
  localparam logic [5:0] OP_CALL  = 6'b000011;
  localparam logic [5:0] OP_RET   = 6'b000001;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  // ALU operation codes (3 significant bits).
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_FUNCT = 3'b100;
  localparam logic [2:0] ALU_MUL   = 3'b101;
  localparam logic [2:0] ALU_DIV   = 3'b110;

  // ALU B-operand select.
  localparam logic [1:0] ALUSRC_REG  = 2'b00;
  localparam logic [1:0] ALUSRC_SIMM = 2'b01;
  localparam logic [1:0] ALUSRC_ZIMM = 2'b10;
  localparam logic [1:0] ALUSRC_PC   = 2'b11;

  // Next-PC select.
  localparam logic [1:0] PCSRC_NEXT   = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_STACK  = 2'b11;

  // Stage encodings, visible on the stage output.
  localparam logic [2:0] ST_FETCH   = 3'b000;
  localparam logic [2:0] ST_DECODE  = 3'b001;
  localparam logic [2:0] ST_EXECUTE = 3'b010;
  localparam logic [2:0] ST_MEM     = 3'b011;
  localparam logic [2:0] ST_WB      = 3'b100;
  localparam logic [2:0] ST_HALTED  = 3'b101;
  localparam logic [2:0] ST_TRAP    = 3'b110;

  // Decoded instruction: one-hot class plus the per-opcode ALU settings.
  typedef struct packed {
    logic       alu;
    logic       muldiv;
    logic       mem_ld;
    logic       mem_st;
    logic       jump;
    logic       call;
    logic       ret;
    logic       branch;
    logic       halt;
    logic       illegal;
    logic       rtype_dst;  // writeback targets rd (R-type, MUL, DIV)
    logic       br_inv;     // branch taken on ~flag (JR)
    logic [2:0] alu_op;
    logic [1:0] alu_src;
  } ctrl_class_t;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control-unit bundle: instruction/status inputs and datapath strobes.
// master = instruction-side driver (IR, ALU flag, stack status),
// slave  = the control unit.
interface multicycle_control_unit_if #(
  parameter int unsigned OPW     = 6,
  parameter int unsigned ALUOP_W = 3
);
  logic [OPW-1:0]     opcode;
  logic               flag;
  logic               stall;
  logic               resume;
  logic               stack_full;
  logic               stack_empty;

  logic               memRead;
  logic               memWrite;
  logic               memToReg;
  logic               regWrite;
  logic               regDst;
  logic               PCWrite;
  logic               push;
  logic               pop;
  logic [1:0]         pcSrc;
  logic [1:0]         aluSrc;
  logic [ALUOP_W-1:0] aluOp;
  logic [2:0]         stage;
  logic               halted;
  logic               illegal;

  modport master (
    output opcode, flag, stall, resume, stack_full, stack_empty,
    input  memRead, memWrite, memToReg, regWrite, regDst, PCWrite, push, pop,
           pcSrc, aluSrc, aluOp, stage, halted, illegal
  );

  modport slave (
    input  opcode, flag, stall, resume, stack_full, stack_empty,
    output memRead, memWrite, memToReg, regWrite, regDst, PCWrite, push, pop,
           pcSrc, aluSrc, aluOp, stage, halted, illegal
  );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational opcode classifier.
// Ports: opcode (latched instruction opcode) -> cls (class one-hot plus
// ALU op / operand select for ALU-class instructions).
module ctrl_decode
  import musa_ctrl_pkg::*;
#(
  parameter int unsigned    OPW     = 6,
  parameter logic [OPW-1:0] HALT_OP = OPW'(OP_HALT)
) (
  input  logic [OPW-1:0] opcode,
  output ctrl_class_t    cls
);

  // HALT_OP is a parameter, so it is matched ahead of the fixed table.
  always_comb begin
    cls = '0;
    if (opcode == HALT_OP) begin
      cls.halt = 1'b1;
    end else begin
      case (opcode)
        OPW'(OP_RTYPE): begin cls.alu = 1'b1; cls.rtype_dst = 1'b1; cls.alu_op = ALU_FUNCT; end
        OPW'(OP_MUL):   begin cls.muldiv = 1'b1; cls.rtype_dst = 1'b1; cls.alu_op = ALU_MUL; end
        OPW'(OP_DIV):   begin cls.muldiv = 1'b1; cls.rtype_dst = 1'b1; cls.alu_op = ALU_DIV; end
        OPW'(OP_ADDI):  begin cls.alu = 1'b1; cls.alu_op = ALU_ADD; cls.alu_src = ALUSRC_SIMM; end
        OPW'(OP_SUBI):  begin cls.alu = 1'b1; cls.alu_op = ALU_SUB; cls.alu_src = ALUSRC_SIMM; end
        OPW'(OP_ANDI):  begin cls.alu = 1'b1; cls.alu_op = ALU_AND; cls.alu_src = ALUSRC_ZIMM; end
        OPW'(OP_ORI):   begin cls.alu = 1'b1; cls.alu_op = ALU_OR;  cls.alu_src = ALUSRC_ZIMM; end
        OPW'(OP_LW):    cls.mem_ld = 1'b1;
        OPW'(OP_SW):    cls.mem_st = 1'b1;
        OPW'(OP_JPC):   cls.jump   = 1'b1;
        OPW'(OP_CALL):  cls.call   = 1'b1;
        OPW'(OP_RET):   cls.ret    = 1'b1;
        OPW'(OP_BRFL):  cls.branch = 1'b1;
        OPW'(OP_JR):    begin cls.branch = 1'b1; cls.br_inv = 1'b1; end
        default:        cls.illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control unit: sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK,
// counts MUL/DIV execute cycles, and handles HALT/resume and traps.
// Ports: clk, rst (async, active-high), bus (slave side of the control
// bundle: opcode/flag/stall/resume/stack status in, datapath controls,
// stage, halted and illegal out).
// Controls decode the current state and latched opcode; the write strobes
// are qualified by the live stall, flag and stack-status inputs within the
// cycle, so they are combinational by nature.
module multicycle_control_unit
  import musa_ctrl_pkg::*;
#(
  parameter int unsigned    OPW           = 6,
  parameter int unsigned    ALUOP_W       = 3,
  parameter int unsigned    MULDIV_CYCLES = 4,
  parameter logic [OPW-1:0] HALT_OP       = OPW'(OP_HALT)
) (
  input logic                      clk,
  input logic                      rst,
  multicycle_control_unit_if.slave bus
);

  localparam int unsigned CNT_W = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;

  logic [2:0]       state_q, state_d;
  logic [OPW-1:0]   op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctrl_class_t      cls;
  logic             run;

  logic       mem_read, mem_write, mem_to_reg, reg_write, reg_dst;
  logic       pc_write, push_s, pop_s, halted_s, illegal_s;
  logic [1:0] pc_src, alu_src;
  logic [2:0] alu_op;

  assign run = ~bus.stall;

  ctrl_decode #(
    .OPW     (OPW),
    .HALT_OP (HALT_OP)
  ) u_decode (
    .opcode (op_q),
    .cls    (cls)
  );

  // State, latched opcode and execute wait counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_FETCH;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and datapath controls.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    pc_write   = 1'b0;
    push_s     = 1'b0;
    pop_s      = 1'b0;
    halted_s   = 1'b0;
    illegal_s  = 1'b0;
    pc_src     = PCSRC_NEXT;
    alu_src    = ALUSRC_REG;
    alu_op     = ALU_ADD;

    case (state_q)
      ST_FETCH: begin
        pc_write = run;
        if (run) begin
          state_d = ST_DECODE;
          op_d    = bus.opcode;
        end
      end

      ST_DECODE: begin
        if (run) begin
          if (cls.halt) begin
            state_d = ST_HALTED;
          end else if (cls.illegal) begin
            state_d = ST_TRAP;
          end else begin
            state_d = ST_EXECUTE;
            cnt_d   = cls.muldiv ? CNT_W'(MULDIV_CYCLES - 1) : '0;
          end
        end
      end

      ST_EXECUTE: begin
        if (cls.alu || cls.muldiv) begin
          alu_op  = cls.alu_op;
          alu_src = cls.alu_src;
          if (run) begin
            if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
            else             state_d = ST_WB;
          end
        end else if (cls.mem_ld || cls.mem_st) begin
          alu_op  = ALU_ADD;
          alu_src = ALUSRC_SIMM;
          if (run) state_d = ST_MEM;
        end else if (cls.jump) begin
          pc_write = run;
          pc_src   = PCSRC_JUMP;
          if (run) state_d = ST_FETCH;
        end else if (cls.call) begin
          // Stack check only counts in a non-stalled cycle.
          if (run && bus.stack_full) begin
            state_d = ST_TRAP;
          end else begin
            push_s   = run;
            pc_write = run;
            pc_src   = PCSRC_JUMP;
            if (run) state_d = ST_FETCH;
          end
        end else if (cls.ret) begin
          if (run && bus.stack_empty) begin
            state_d = ST_TRAP;
          end else begin
            pop_s    = run;
            pc_write = run;
            pc_src   = PCSRC_STACK;
            if (run) state_d = ST_FETCH;
          end
        end else if (cls.branch) begin
          alu_op   = ALU_SUB;
          pc_src   = PCSRC_BRANCH;
          pc_write = run & (bus.flag ^ cls.br_inv);
          if (run) state_d = ST_FETCH;
        end else begin
          if (run) state_d = ST_FETCH;
        end
      end

      ST_MEM: begin
        mem_read  = run & cls.mem_ld;
        mem_write = run & cls.mem_st;
        if (run) state_d = cls.mem_ld ? ST_WB : ST_FETCH;
      end

      ST_WB: begin
        reg_write  = run;
        mem_to_reg = cls.mem_ld;
        reg_dst    = cls.rtype_dst;
        if (run) state_d = ST_FETCH;
      end

      ST_HALTED: begin
        halted_s = 1'b1;
        if (bus.resume) state_d = ST_FETCH;
      end

      ST_TRAP: begin
        illegal_s = 1'b1;
      end

      default: state_d = ST_FETCH;
    endcase
  end

  // Reset blanks every control immediately, not only at the next edge.
  assign bus.memRead  = mem_read   & ~rst;
  assign bus.memWrite = mem_write  & ~rst;
  assign bus.memToReg = mem_to_reg & ~rst;
  assign bus.regWrite = reg_write  & ~rst;
  assign bus.regDst   = reg_dst    & ~rst;
  assign bus.PCWrite  = pc_write   & ~rst;
  assign bus.push     = push_s     & ~rst;
  assign bus.pop      = pop_s      & ~rst;
  assign bus.halted   = halted_s   & ~rst;
  assign bus.illegal  = illegal_s  & ~rst;
  assign bus.pcSrc    = rst ? 2'b00 : pc_src;
  assign bus.aluSrc   = rst ? 2'b00 : alu_src;
  assign bus.aluOp    = rst ? '0 : ALUOP_W'(alu_op);
  assign bus.stage    = state_q;

endmodule
